// File: rtl/io_mmio_dev.sv
// ============================================================================
// io_mmio_dev: CPU-bus peripheral with LEDs, debounced switch capture and
// a scanned 8-digit hex display.                               Rev 1.0
// ============================================================================
`default_nettype none

module io_mmio_dev #(
  parameter int DB_CYCLES   = 1000000,
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic [15:0] led,
  output logic [2:0]  seg_an,
  output logic [3:0]  seg_data
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [7:0] A_LED  = 8'h00;
  localparam logic [7:0] A_IRDY = 8'h04;
  localparam logic [7:0] A_IDAT = 8'h08;
  localparam logic [7:0] A_ORDY = 8'h0C;
  localparam logic [7:0] A_DISP = 8'h10;
  localparam logic [7:0] A_SW   = 8'h14;

  logic              btn_s1_q, btn_s2_q;
  logic [15:0]       sw_s1_q, sw_s2_q;
  logic              db_level_q, db_level_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [15:0]       led_q, led_d;
  logic [15:0]       in_data_q, in_data_d;
  logic              in_ready_q, in_ready_d;
  logic [31:0]       disp_val_q, disp_val_d;
  logic              out_ready_q, out_ready_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]        seg_an_q, seg_an_d;
  logic [3:0]        seg_data_q, seg_data_d;
  logic              press, rd_clr;

  always_comb begin
    db_level_d  = db_level_q;
    db_cnt_d    = '0;
    press       = 1'b0;
    led_d       = led_q;
    in_data_d   = in_data_q;
    in_ready_d  = in_ready_q;
    disp_val_d  = disp_val_q;
    out_ready_d = out_ready_q;
    hold_cnt_d  = hold_cnt_q;
    scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
    seg_an_d    = seg_an_q;
    rd_clr      = io_rd && (io_addr == A_IDAT);

    if (btn_s2_q != db_level_q) begin
      if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
        db_level_d = ~db_level_q;
        press      = ~db_level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    // A press coinciding with the read-clear wins and refills the slot.
    if (press && (!in_ready_q || rd_clr)) begin
      in_data_d  = sw_s2_q;
      in_ready_d = 1'b1;
    end else if (rd_clr) begin
      in_ready_d = 1'b0;
    end

    if (io_we && (io_addr == A_LED)) led_d = io_dout[15:0];

    if (io_we && (io_addr == A_DISP) && out_ready_q) begin
      disp_val_d  = io_dout;
      out_ready_d = 1'b0;
      hold_cnt_d  = HOLD_W'(HOLD_CYCLES - 1);
    end else if (!out_ready_q) begin
      if (hold_cnt_q == '0) out_ready_d = 1'b1;
      else                  hold_cnt_d  = hold_cnt_q - HOLD_W'(1);
    end

    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      seg_an_d   = seg_an_q + 3'd1;
    end
    seg_data_d = disp_val_d[{seg_an_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      db_level_q  <= 1'b0;
      db_cnt_q    <= '0;
      led_q       <= '0;
      in_data_q   <= '0;
      in_ready_q  <= 1'b0;
      disp_val_q  <= '0;
      out_ready_q <= 1'b1;
      hold_cnt_q  <= '0;
      scan_cnt_q  <= '0;
      seg_an_q    <= '0;
      seg_data_q  <= '0;
    end else begin
      btn_s1_q    <= btn;
      btn_s2_q    <= btn_s1_q;
      sw_s1_q     <= sw;
      sw_s2_q     <= sw_s1_q;
      db_level_q  <= db_level_d;
      db_cnt_q    <= db_cnt_d;
      led_q       <= led_d;
      in_data_q   <= in_data_d;
      in_ready_q  <= in_ready_d;
      disp_val_q  <= disp_val_d;
      out_ready_q <= out_ready_d;
      hold_cnt_q  <= hold_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      seg_an_q    <= seg_an_d;
      seg_data_q  <= seg_data_d;
    end
  end

  always_comb begin
    io_din = '0;
    case (io_addr)
      A_LED:   io_din = {16'b0, led_q};
      A_IRDY:  io_din = {31'b0, in_ready_q};
      A_IDAT:  io_din = {16'b0, in_data_q};
      A_ORDY:  io_din = {31'b0, out_ready_q};
      A_DISP:  io_din = disp_val_q;
      A_SW:    io_din = {16'b0, sw_s2_q};
      default: io_din = '0;
    endcase
  end

  assign led      = led_q;
  assign seg_an   = seg_an_q;
  assign seg_data = seg_data_q;

endmodule

`default_nettype wire
